riscv_irq_arbiter: RTL
======================

RISCV_IRQ_ARBITER -- requirements
Module: riscv_irq_arbiter

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 32, number of interrupt lines (1..32).
REQ-002 SHALL have parameter PULP_SECURE, default 0; when 1, enables per-line secure tagging.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port setback_i, input, 1, synchronous soft-reset.
REQ-006 SHALL have port irq_lines_i, input, NUM_IRQ, raw interrupt sources; rising edge = event.
REQ-007 SHALL have port sw_set_i, input, NUM_IRQ, software set-pending strobes, one cycle each.
REQ-008 SHALL have port sw_clr_i, input, NUM_IRQ, software clear-pending strobes, one cycle each.
REQ-009 SHALL have port mask_i, input, NUM_IRQ, enable per line (1 = may be requested).
REQ-010 SHALL have port sec_mask_i, input, NUM_IRQ, secure tag per line.
REQ-011 SHALL have port irq_o, input-to-core request, output, 1, level request to the core.
REQ-012 SHALL have port irq_id_o, output, 5, id of the requested interrupt.
REQ-013 SHALL have port irq_sec_o, output, 1, secure tag of the requested interrupt.
REQ-014 SHALL have port irq_ack_i, input, 1, one-cycle acknowledge from the core.
REQ-015 SHALL have port irq_ack_id_i, input, 5, id being acknowledged.
REQ-016 SHALL have port pending_o, output, NUM_IRQ, current pending register.

Function
REQ-017 SHALL detect per-line rising edges with a one-flop history register (edge = line & ~prev).
REQ-018 SHALL set pending[i] on an edge of line i or on sw_set_i[i].
REQ-019 SHALL clear pending[i] on sw_clr_i[i] or on irq_ack_i with irq_ack_id_i == i.
REQ-020 SHALL let set win over clear when both hit the same bit in one cycle.
REQ-021 SHALL ignore irq_ack_id_i >= NUM_IRQ for clearing; the FSM still advances.
REQ-022 SHALL select among pending & mask_i the lowest index as highest priority, combinationally.
REQ-023 SHALL implement FSM states IDLE, REQ, COOL; reset state IDLE.
REQ-024 SHALL, in IDLE with any pending & mask_i bit set, latch the winning id and sec_mask_i[id] (forced 0 when PULP_SECURE=0), and move to REQ next cycle.
REQ-025 SHALL assert irq_o only in REQ, with irq_id_o/irq_sec_o held stable from the latch for the whole of REQ.
REQ-026 SHALL, in REQ, stay in REQ until irq_ack_i; masking, clearing or higher-priority arrivals do not withdraw or change the request.
REQ-027 SHALL, on irq_ack_i in REQ, move to COOL; COOL lasts exactly one cycle with irq_o=0, then returns to IDLE.
REQ-028 SHALL, on irq_ack_i in IDLE or COOL, apply only the pending clear; no state change.
REQ-029 SHALL give minimum latency edge-to-irq_o of 2 cycles: pending set at edge+1, REQ at edge+2.
REQ-030 SHALL give back-to-back requests at most every 3 cycles (REQ, COOL, IDLE).
REQ-031 SHALL, on setback_i, clear pending, history, latches, and force IDLE; setback overrides all same-cycle events.

Reset
REQ-032 SHALL reset asynchronously on rst_n low: pending=0, history=0, id latch=0, sec latch=0, state IDLE.
REQ-033 SHALL hold outputs at irq_o=0, irq_id_o=0, irq_sec_o=0, pending_o=0 during reset.
REQ-034 SHALL treat lines already high at reset release as not edges (history samples them from the first clock).

Structure
REQ-035 SHALL place the FSM state enum type and the IRQ id width constant (5) in riscv_defines.
REQ-036 SHALL contain one sub-module, riscv_irq_prio_enc (NUM_IRQ-bit lowest-index priority encoder with valid output).

Verification
REQ-037 SHALL check: line 3 rises at cycle 0, mask all-ones -> pending_o[3]=1 at cycle 1, irq_o=1, irq_id_o=3 at cycle 2.
REQ-038 SHALL check: lines 5 and 9 rise together -> id 5 first; ack id 5 -> COOL 1 cycle -> IDLE -> REQ with id 9.
REQ-039 SHALL check: in REQ with id 7, mask_i[7] dropped and sw_clr_i[7] -> irq_o and irq_id_o=7 held until ack.
REQ-040 SHALL check: sw_set_i[2] and ack id 2 in the same cycle -> pending_o[2] stays 1.
REQ-041 SHALL check: PULP_SECURE=1, sec_mask_i[4]=1, line 4 edge -> irq_sec_o=1 throughout REQ; PULP_SECURE=0 -> 0.
REQ-042 SHALL check: rst_n low while in REQ -> irq_o=0, pending_o=0 immediately; line held high after release -> no request.

Source files
------------

// File: rtl/riscv_defines.sv
// Shared types and constants for the RISC-V interrupt arbiter.
// Holds the arbiter FSM state encoding and the interrupt id width.
package riscv_defines;

    localparam int unsigned IRQ_ID_W = 5;

    typedef enum logic [1:0] {
        IRQ_IDLE = 2'd0,
        IRQ_REQ  = 2'd1,
        IRQ_COOL = 2'd2
    } irq_state_e;

endpackage : riscv_defines

// File: rtl/riscv_irq_prio_enc.sv
// Lowest-index-wins priority encoder over NUM_IRQ request bits.
// Purely combinational; o_vld_c is high when any request bit is set.
module riscv_irq_prio_enc
    import riscv_defines::*;
#(
    parameter int unsigned NUM_IRQ = 32
) (
    input  logic [NUM_IRQ-1:0]  i_req,
    output logic [IRQ_ID_W-1:0] o_id_c,
    output logic                o_vld_c
);

    // Scan from the top down so the lowest set index is the last writer.
    always_comb begin
        o_id_c  = '0;
        o_vld_c = |i_req;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_id_c = IRQ_ID_W'(i);
            end
        end
    end

endmodule : riscv_irq_prio_enc

// File: rtl/riscv_irq_arbiter.sv
// Interrupt arbiter: edge/software pending capture, lowest-index priority,
// and an IDLE/REQ/COOL handshake that holds one request stable until ack.
module riscv_irq_arbiter
    import riscv_defines::*;
#(
    parameter int unsigned NUM_IRQ     = 32,
    parameter int unsigned PULP_SECURE = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                setback_i,
    input  logic [NUM_IRQ-1:0]  irq_lines_i,
    input  logic [NUM_IRQ-1:0]  sw_set_i,
    input  logic [NUM_IRQ-1:0]  sw_clr_i,
    input  logic [NUM_IRQ-1:0]  mask_i,
    input  logic [NUM_IRQ-1:0]  sec_mask_i,
    output logic                irq_o,
    output logic [IRQ_ID_W-1:0] irq_id_o,
    output logic                irq_sec_o,
    input  logic                irq_ack_i,
    input  logic [IRQ_ID_W-1:0] irq_ack_id_i,
    output logic [NUM_IRQ-1:0]  pending_o
);

    irq_state_e            r_state;
    irq_state_e            w_state_nxt;
    logic [NUM_IRQ-1:0]    r_hist;
    logic                  r_hist_vld;
    logic [NUM_IRQ-1:0]    r_pend;
    logic [NUM_IRQ-1:0]    w_pend_nxt;
    logic [NUM_IRQ-1:0]    w_edge;
    logic [NUM_IRQ-1:0]    w_ack_clr;
    logic [NUM_IRQ-1:0]    w_cand;
    logic [IRQ_ID_W-1:0]   w_win_id;
    logic                  w_win_vld;
    logic                  w_win_sec;
    logic                  w_latch;
    logic                  w_irq_nxt;
    logic [IRQ_ID_W-1:0]   r_id;
    logic                  r_sec;
    logic                  r_irq;

    // History is only trusted after the first post-reset clock, so lines
    // already high when reset releases are not taken as events.
    assign w_edge = r_hist_vld ? (irq_lines_i & ~r_hist) : '0;

    // Ack ids beyond NUM_IRQ fall outside this decode and clear nothing.
    always_comb begin
        w_ack_clr = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            w_ack_clr[i] = irq_ack_i && (irq_ack_id_i == IRQ_ID_W'(i));
        end
    end

    // Set terms are OR-ed in after the clear so set wins on a collision.
    assign w_pend_nxt = (r_pend & ~(sw_clr_i | w_ack_clr)) | w_edge | sw_set_i;
    assign w_cand     = r_pend & mask_i;

    riscv_irq_prio_enc #(
        .NUM_IRQ (NUM_IRQ)
    ) u_prio_enc (
        .i_req   (w_cand),
        .o_id_c  (w_win_id),
        .o_vld_c (w_win_vld)
    );

    always_comb begin
        w_win_sec = 1'b0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (w_win_id == IRQ_ID_W'(i)) begin
                w_win_sec = sec_mask_i[i];
            end
        end
        if (PULP_SECURE == 0) begin
            w_win_sec = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hist     <= '0;
            r_hist_vld <= 1'b0;
            r_pend     <= '0;
        end else if (setback_i) begin
            r_hist     <= '0;
            r_pend     <= '0;
        end else begin
            r_hist     <= irq_lines_i;
            r_hist_vld <= 1'b1;
            r_pend     <= w_pend_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IRQ_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (setback_i) begin
            w_state_nxt = IRQ_IDLE;
        end else begin
            case (r_state)
                IRQ_IDLE: if (w_win_vld) w_state_nxt = IRQ_REQ;
                IRQ_REQ:  if (irq_ack_i) w_state_nxt = IRQ_COOL;
                IRQ_COOL: w_state_nxt = IRQ_IDLE;
                default:  w_state_nxt = IRQ_IDLE;
            endcase
        end
    end

    always_comb begin
        w_latch   = 1'b0;
        w_irq_nxt = (w_state_nxt == IRQ_REQ);
        if (!setback_i && (r_state == IRQ_IDLE) && w_win_vld) begin
            w_latch = 1'b1;
        end
    end

    // Request outputs are frozen from the IDLE latch until the next latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_id  <= '0;
            r_sec <= 1'b0;
            r_irq <= 1'b0;
        end else if (setback_i) begin
            r_id  <= '0;
            r_sec <= 1'b0;
            r_irq <= 1'b0;
        end else begin
            r_irq <= w_irq_nxt;
            if (w_latch) begin
                r_id  <= w_win_id;
                r_sec <= w_win_sec;
            end
        end
    end

    assign irq_o     = r_irq;
    assign irq_id_o  = r_id;
    assign irq_sec_o = r_sec;
    assign pending_o = r_pend;

endmodule : riscv_irq_arbiter
